// File: rtl/sram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and constants for the SRAM port arbiter slice.
//   - state_t : arbiter FSM states
//   - owner_t : owner codes reported on the owner debug output
//   - *_DEF   : default address / write-data / read-data widths
// ---------------------------------------------------------------------------
package sram_arb_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int WDATA_W_DEF = 32;
   localparam int RDATA_W_DEF = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_D = 2'd1,
      SERVE_I = 2'd2,
      RESP    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_D    = 2'b01,
      OWN_I    = 2'b10
   } owner_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
//   Bundles the D requester, I requester and SRAM controller signals of the
//   arbiter.
//   Modports:
//     slave  : the arbiter's view (requests and SRAM results in, grants out)
//     master : the environment's view (drives requests and SRAM results)
//   Signals:
//     d_read_en/d_write_en/d_address/d_wdata -> D request
//     d_rdata/d_ready                         <- D read data and completion
//     i_read_en/i_address                     -> I request
//     i_rdata/i_ready                         <- I read data and completion
//     read_en/write_en/address/writeData      <- to SRAM controller
//     readData/ready                          -> from SRAM controller
//     owner                                   <- current owner (debug)
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int WDATA_W = WDATA_W_DEF,
   parameter int RDATA_W = RDATA_W_DEF
);

   logic               d_read_en;
   logic               d_write_en;
   logic [ADDR_W-1:0]  d_address;
   logic [WDATA_W-1:0] d_wdata;
   logic [RDATA_W-1:0] d_rdata;
   logic               d_ready;

   logic               i_read_en;
   logic [ADDR_W-1:0]  i_address;
   logic [RDATA_W-1:0] i_rdata;
   logic               i_ready;

   logic               read_en;
   logic               write_en;
   logic [ADDR_W-1:0]  address;
   logic [WDATA_W-1:0] writeData;
   logic [RDATA_W-1:0] readData;
   logic               ready;

   logic [1:0]         owner;

   modport slave (
      input  d_read_en, d_write_en, d_address, d_wdata,
      input  i_read_en, i_address,
      input  readData, ready,
      output d_rdata, d_ready, i_rdata, i_ready,
      output read_en, write_en, address, writeData,
      output owner
   );

   modport master (
      output d_read_en, d_write_en, d_address, d_wdata,
      output i_read_en, i_address,
      output readData, ready,
      input  d_rdata, d_ready, i_rdata, i_ready,
      input  read_en, write_en, address, writeData,
      input  owner
   );

endinterface

// File: rtl/sram_port_arbiter_pick.sv
// ---------------------------------------------------------------------------
// sram_arb_pick
//   Combinational winner select between the D and I requesters.
//   Build option (macro ARB_ROUND_ROBIN_EN):
//     undefined : fixed priority, D always wins a tie so a MEM-stage access
//                 can never be starved behind instruction fetch
//     defined   : on a tie, the requester that was NOT granted last wins
//   With only one requester active both builds grant that requester.
//   Ports:
//     d_req, i_req -> pending requests
//     last_owner   -> owner of the most recent grant
//     grant_d      <- D wins this cycle
//     grant_i      <- I wins this cycle
// ---------------------------------------------------------------------------
module sram_arb_pick
   import sram_arb_pkg::*;
(
   input  logic   d_req,
   input  logic   i_req,
   input  owner_t last_owner,
   output logic   grant_d,
   output logic   grant_i
);

`ifndef ARB_ROUND_ROBIN_EN
   logic [1:0] unused_last_owner;
   assign unused_last_owner = last_owner;
`endif

   // Tie resolution is the only thing the build option changes; a lone
   // requester is always granted.
   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (last_owner == OWN_D) begin
            grant_i = 1'b1;
         end else begin
            grant_d = 1'b1;
         end
`else
         grant_d = 1'b1;
`endif
      end else if (d_req) begin
         grant_d = 1'b1;
      end else if (i_req) begin
         grant_i = 1'b1;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares the single SRAM controller port between instruction fetch (I)
//   and data memory (D). One transaction is served to completion, then the
//   owner gets a one-cycle ready pulse together with its read data.
//   Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking
//   instead of fixed D-over-I priority.
//   Ports:
//     clk  -> rising-edge clock
//     rst  -> asynchronous active-high reset
//     bus  -> sram_port_arbiter_if.slave (requesters + SRAM controller)
// ---------------------------------------------------------------------------
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int WDATA_W = WDATA_W_DEF,
   parameter int RDATA_W = RDATA_W_DEF
)
(
   input  logic               clk,
   input  logic               rst,
   sram_port_arbiter_if.slave bus
);

   state_t             state;
   owner_t             owner_q;
   owner_t             last_owner;
   logic               read_en_q;
   logic               write_en_q;
   logic [ADDR_W-1:0]  address_q;
   logic [WDATA_W-1:0] write_data_q;
   logic [RDATA_W-1:0] d_rdata_q;
   logic [RDATA_W-1:0] i_rdata_q;
   logic               d_ready_q;
   logic               i_ready_q;

   logic               d_req;
   logic               i_req;
   logic               grant_d;
   logic               grant_i;

   // A simultaneous read+write from D counts as a single request (a write).
   assign d_req = bus.d_read_en | bus.d_write_en;
   assign i_req = bus.i_read_en;

   sram_arb_pick u_pick (
      .d_req      (d_req),
      .i_req      (i_req),
      .last_owner (last_owner),
      .grant_d    (grant_d),
      .grant_i    (grant_i)
   );

   // Main FSM. The SRAM-side registers double as the captured request, so
   // once granted the transaction no longer depends on requester inputs.
   // RESP is a mandatory gap cycle: the requester drops or changes its
   // request while we are there, so a stale request is never re-granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         owner_q      <= OWN_NONE;
         last_owner   <= OWN_I;
         read_en_q    <= 1'b0;
         write_en_q   <= 1'b0;
         address_q    <= '0;
         write_data_q <= '0;
         d_rdata_q    <= '0;
         i_rdata_q    <= '0;
         d_ready_q    <= 1'b0;
         i_ready_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state        <= SERVE_D;
                  owner_q      <= OWN_D;
                  last_owner   <= OWN_D;
                  address_q    <= bus.d_address;
                  write_data_q <= bus.d_wdata;
                  write_en_q   <= bus.d_write_en;
                  read_en_q    <= ~bus.d_write_en;
               end else if (grant_i) begin
                  state        <= SERVE_I;
                  owner_q      <= OWN_I;
                  last_owner   <= OWN_I;
                  address_q    <= bus.i_address;
                  write_data_q <= '0;
                  write_en_q   <= 1'b0;
                  read_en_q    <= 1'b1;
               end
            end

            SERVE_D, SERVE_I: begin
               if (bus.ready) begin
                  if (read_en_q) begin
                     if (state == SERVE_D) begin
                        d_rdata_q <= bus.readData;
                     end else begin
                        i_rdata_q <= bus.readData;
                     end
                  end
                  if (state == SERVE_D) begin
                     d_ready_q <= 1'b1;
                  end else begin
                     i_ready_q <= 1'b1;
                  end
                  read_en_q  <= 1'b0;
                  write_en_q <= 1'b0;
                  state      <= RESP;
               end
            end

            RESP: begin
               d_ready_q <= 1'b0;
               i_ready_q <= 1'b0;
               owner_q   <= OWN_NONE;
               state     <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.read_en   = read_en_q;
   assign bus.write_en  = write_en_q;
   assign bus.address   = address_q;
   assign bus.writeData = write_data_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.i_ready   = i_ready_q;
   assign bus.owner     = owner_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Self-checking bench for sram_port_arbiter: reset, single-transaction
//   vector table, tie/contention order, reset mid-transaction and a
//   randomized run against a transaction-level reference model.
//   Honours ARB_ROUND_ROBIN_EN when computing tie winners.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_port_arbiter;
   import sram_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [63:0] lastD = '0;
   logic [63:0] lastI = '0;

   always #5 clk = ~clk;

   sram_port_arbiter_if bus ();

   sram_port_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        d_rd;
      logic        d_wr;
      logic        i_rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [63:0] rdata;
      logic        exp_rd;
      logic        exp_wr;
      logic [1:0]  exp_owner;
      logic [1:0]  exp_rdy;
      logic        upd_d;
      logic        upd_i;
   } vec_t;

   vec_t vecs[6];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic d_rd, input logic d_wr, input logic [31:0] d_addr,
                                input logic [31:0] d_wd, input logic i_rd, input logic [31:0] i_addr);
      bus.d_read_en  = d_rd;
      bus.d_write_en = d_wr;
      bus.d_address  = d_addr;
      bus.d_wdata    = d_wd;
      bus.i_read_en  = i_rd;
      bus.i_address  = i_addr;
   endtask

   // Tie/lone-request winner straight from the arbitration rules.
   function automatic logic [1:0] pickWinner(input logic dReq, input logic iReq, input logic [1:0] last);
      if (dReq && iReq) begin
`ifdef ARB_ROUND_ROBIN_EN
         return (last == OWN_D) ? OWN_I : OWN_D;
`else
         return OWN_D;
`endif
      end
      if (dReq) return OWN_D;
      if (iReq) return OWN_I;
      return OWN_NONE;
   endfunction

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      bus.ready    = 1'b0;
      bus.readData = '0;
      step();
      step();
      rst   = 1'b0;
      lastD = '0;
      lastI = '0;
   endtask

   // One isolated transaction; SRAM answers after v.lat serve cycles.
   task automatic runVector(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      applyStimulus(v.d_rd, v.d_wr, v.addr, v.wdata, v.i_rd, v.addr);
      for (int c = 1; c <= v.lat; c++) begin
         step();
         checkOutput({tag, " enables"}, {bus.read_en, bus.write_en}, {v.exp_rd, v.exp_wr});
         checkOutput({tag, " address"}, bus.address, v.addr);
         checkOutput({tag, " owner"}, bus.owner, v.exp_owner);
         checkOutput({tag, " early ready"}, {bus.d_ready, bus.i_ready}, 2'b00);
         if (v.exp_wr) checkOutput({tag, " writeData"}, bus.writeData, v.wdata);
         if (c == v.lat) begin
            bus.ready    = 1'b1;
            bus.readData = v.rdata;
         end
      end
      step();
      bus.ready    = 1'b0;
      bus.readData = 64'h0BAD_0BAD_0BAD_0BAD;
      if (v.upd_d) lastD = v.rdata;
      if (v.upd_i) lastI = v.rdata;
      checkOutput({tag, " ready pulse"}, {bus.d_ready, bus.i_ready}, v.exp_rdy);
      checkOutput({tag, " d_rdata"}, bus.d_rdata, lastD);
      checkOutput({tag, " i_rdata"}, bus.i_rdata, lastI);
      checkOutput({tag, " resp enables"}, {bus.read_en, bus.write_en}, 2'b00);
      checkOutput({tag, " resp owner"}, bus.owner, v.exp_owner);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      step();
      checkOutput({tag, " after ready"}, {bus.d_ready, bus.i_ready, bus.owner}, 4'b0000);
   endtask

   // Both requesters keep re-requesting; grant order and spacing checked
   // against the rule-derived expected winner each round.
   task automatic runContention(input int nD, input int nI);
      int         dLeft = nD;
      int         iLeft = nI;
      logic [1:0] last  = OWN_I;
      logic [1:0] expWho;
      logic [63:0] rd;
      int         waited;
      int         round = 0;
      applyStimulus(nD > 0, 1'b0, 32'h20, 32'h0, nI > 0, 32'h30);
      while (dLeft + iLeft > 0) begin
         expWho = pickWinner(dLeft > 0, iLeft > 0, last);
         waited = 0;
         do begin
            step();
            waited++;
         end while (bus.owner == 2'b00 && waited < 8);
         checkOutput($sformatf("tie grant %0d", round), bus.owner, expWho);
         checkOutput($sformatf("tie spacing %0d", round), waited, (round == 0) ? 1 : 2);
         checkOutput($sformatf("tie address %0d", round), bus.address,
                     (expWho == OWN_D) ? 32'h20 + 32'(4 * (nD - dLeft)) : 32'h30 + 32'(4 * (nI - iLeft)));
         rd = {$urandom, $urandom};
         bus.ready    = 1'b1;
         bus.readData = rd;
         step();
         bus.ready = 1'b0;
         checkOutput($sformatf("tie ready %0d", round), {bus.d_ready, bus.i_ready},
                     (expWho == OWN_D) ? 2'b10 : 2'b01);
         if (expWho == OWN_D) begin
            checkOutput($sformatf("tie d_rdata %0d", round), bus.d_rdata, rd);
            dLeft--;
            if (dLeft > 0) bus.d_address = bus.d_address + 32'd4;
            else bus.d_read_en = 1'b0;
         end else begin
            checkOutput($sformatf("tie i_rdata %0d", round), bus.i_rdata, rd);
            iLeft--;
            if (iLeft > 0) bus.i_address = bus.i_address + 32'd4;
            else bus.i_read_en = 1'b0;
         end
         last = expWho;
         round++;
      end
      step();
   endtask

   task automatic checkServe(input logic capWrite, input logic [31:0] capAddr,
                             input logic [31:0] capWdata, input logic [1:0] who);
      checkOutput("rnd serve enables", {bus.read_en, bus.write_en}, capWrite ? 2'b01 : 2'b10);
      checkOutput("rnd serve address", bus.address, capAddr);
      checkOutput("rnd serve owner", bus.owner, who);
      checkOutput("rnd serve readies", {bus.d_ready, bus.i_ready}, 2'b00);
      if (capWrite) checkOutput("rnd serve writeData", bus.writeData, capWdata);
   endtask

   // Randomized traffic. phase tracks what the arbiter was doing in the
   // previous cycle at transaction level: 0 waiting, 1 transfer, 2 response.
   task automatic runRandom(input int cycles);
      int          phase = 0;
      logic [1:0]  who = OWN_NONE;
      logic [1:0]  last = OWN_I;
      logic        capWrite = 1'b0;
      logic [31:0] capAddr = '0;
      logic [31:0] capWdata = '0;
      int          lat = 0;
      int          cnt = 0;
      logic [63:0] rdataGiven = '0;
      logic        dAct = 1'b0;
      logic [1:0]  dOp = 2'd0;
      logic        iAct = 1'b0;
      logic [31:0] dAddr = '0;
      logic [31:0] dWd = '0;
      logic [31:0] iAddr = '0;
      logic        pDrd = 1'b0;
      logic        pDwr = 1'b0;
      logic        pIrd = 1'b0;
      logic [31:0] pDaddr = '0;
      logic [31:0] pDwd = '0;
      logic [31:0] pIaddr = '0;
      logic        pReal = 1'b0;
      for (int cyc = 0; cyc < cycles; cyc++) begin
         step();
         if (phase == 0) begin
            who = pickWinner(pDrd | pDwr, pIrd, last);
            checkOutput("rnd owner", bus.owner, who);
            if (who != OWN_NONE) begin
               capWrite = (who == OWN_D) && pDwr;
               capAddr  = (who == OWN_D) ? pDaddr : pIaddr;
               capWdata = pDwd;
               last     = who;
               cnt      = 0;
               lat      = $urandom_range(1, 4);
               phase    = 1;
               checkServe(capWrite, capAddr, capWdata, who);
            end else begin
               checkOutput("rnd idle outputs", {bus.read_en, bus.write_en, bus.d_ready, bus.i_ready}, 4'b0000);
            end
         end else if (phase == 1) begin
            if (pReal) begin
               if (!capWrite) begin
                  if (who == OWN_D) lastD = rdataGiven;
                  else lastI = rdataGiven;
               end
               checkOutput("rnd ready pulse", {bus.d_ready, bus.i_ready}, (who == OWN_D) ? 2'b10 : 2'b01);
               checkOutput("rnd d_rdata", bus.d_rdata, lastD);
               checkOutput("rnd i_rdata", bus.i_rdata, lastI);
               checkOutput("rnd resp enables", {bus.read_en, bus.write_en}, 2'b00);
               checkOutput("rnd resp owner", bus.owner, who);
               phase = 2;
            end else begin
               checkServe(capWrite, capAddr, capWdata, who);
            end
         end else begin
            checkOutput("rnd gap outputs", {bus.read_en, bus.write_en, bus.d_ready, bus.i_ready, bus.owner}, 6'b0);
            phase = 0;
         end

         // SRAM responder, with occasional stray ready pulses outside transfers
         pReal     = 1'b0;
         bus.ready = 1'b0;
         bus.readData = {$urandom, $urandom};
         if (phase == 1) begin
            cnt++;
            if (cnt == lat) begin
               rdataGiven   = {$urandom, $urandom};
               bus.readData = rdataGiven;
               bus.ready    = 1'b1;
               pReal        = 1'b1;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            bus.ready = 1'b1;
         end

         // requesters: finish on completion, sometimes drop or scramble mid-transfer
         if (phase == 2) begin
            if (who == OWN_D) dAct = 1'b0;
            else iAct = 1'b0;
         end else if (phase == 1) begin
            if (who == OWN_D && dAct) begin
               if ($urandom_range(0, 7) == 0) dAct = 1'b0;
               else begin
                  dAddr = $urandom;
                  dWd   = $urandom;
                  dOp   = 2'($urandom_range(0, 2));
               end
            end
            if (who == OWN_I && iAct) begin
               if ($urandom_range(0, 7) == 0) iAct = 1'b0;
               else iAddr = $urandom;
            end
         end
         if (!dAct && !(phase == 1 && who == OWN_D) && $urandom_range(0, 2) == 0) begin
            dAct  = 1'b1;
            dOp   = 2'($urandom_range(0, 2));
            dAddr = $urandom;
            dWd   = $urandom;
         end
         if (!iAct && !(phase == 1 && who == OWN_I) && $urandom_range(0, 2) == 0) begin
            iAct  = 1'b1;
            iAddr = $urandom;
         end
         pDrd   = dAct && (dOp != 2'd1);
         pDwr   = dAct && (dOp != 2'd0);
         pIrd   = iAct;
         pDaddr = dAddr;
         pDwd   = dWd;
         pIaddr = iAddr;
         applyStimulus(pDrd, pDwr, pDaddr, pDwd, pIrd, pIaddr);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 5, 64'h0,
                  1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 3, 64'h1111_2222_3333_4444,
                  1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 1, 64'hA5A5_5A5A_0F0F_F0F0,
                  1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h1234_5678, 2, 64'hFFFF_EEEE_DDDD_CCCC,
                  1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 4, 64'h0123_4567_89AB_CDEF,
                  1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 7, 64'hCAFE_F00D_BEEF_0001,
                  1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0};

      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      bus.ready    = 1'b0;
      bus.readData = '0;

      // reset held while idle: everything low, and stays low
      #1;
      checkOutput("reset outputs t0", {bus.read_en, bus.write_en, bus.d_ready, bus.i_ready, bus.owner}, 6'b0);
      for (int c = 0; c < 3; c++) begin
         step();
         checkOutput("reset outputs", {bus.read_en, bus.write_en, bus.d_ready, bus.i_ready, bus.owner}, 6'b0);
         checkOutput("reset address/wdata", {bus.address, bus.writeData}, 64'h0);
         checkOutput("reset rdata", bus.d_rdata | bus.i_rdata, 64'h0);
      end
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++) runVector(vecs[i], i);

      // reset while a D read is in flight: enables fall without a clock edge
      doReset();
      checkOutput("reset clears d_rdata", bus.d_rdata, 64'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0050, 32'h0, 1'b0, 32'h0);
      step();
      checkOutput("mid rst read_en c1", bus.read_en, 1'b1);
      step();
      #1 rst = 1'b1;
      #1;
      checkOutput("mid rst outputs", {bus.read_en, bus.write_en, bus.d_ready, bus.owner}, 5'b0);
      step();
      step();
      checkOutput("mid rst no ready", {bus.d_ready, bus.i_ready}, 2'b00);
      rst = 1'b0;
      step();
      checkOutput("mid rst regrant owner", bus.owner, OWN_D);
      checkOutput("mid rst regrant address", bus.address, 32'h0000_0050);
      bus.ready    = 1'b1;
      bus.readData = 64'h5555_6666_7777_8888;
      step();
      bus.ready = 1'b0;
      checkOutput("mid rst regrant ready", {bus.d_ready, bus.i_ready}, 2'b10);
      checkOutput("mid rst regrant data", bus.d_rdata, 64'h5555_6666_7777_8888);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      step();

      // both requesters held, D re-requests back-to-back
      doReset();
      runContention(4, 4);

      doReset();
      runRandom(3000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
